// File: rtl/token_move_animator.sv
// rtl/token_move_animator.sv - walks player tokens one square per step tick toward committed targets
module token_move_animator #(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int MAX_POS     = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pos_valid,
  input  logic [3:0] p1_pos,
  input  logic [3:0] p2_pos,
  output logic [3:0] p1_disp,
  output logic [3:0] p2_disp,
  output logic       moving,
  output logic       mover_id,
  output logic       step_pulse,
  output logic       turn_done
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [3:0] MAX4 = 4'(MAX_POS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pos_valid_q;
  logic [3:0]    p1_n, p2_n;
  logic          mover_n, step_n, done_n;
  logic [3:0]    tgt1, tgt2;
  logic          diff1, diff2, trigger, tc;

  assign tgt1    = (p1_pos > MAX4) ? MAX4 : p1_pos;
  assign tgt2    = (p2_pos > MAX4) ? MAX4 : p2_pos;
  assign diff1   = (p1_disp != tgt1);
  assign diff2   = (p2_disp != tgt2);
  assign trigger = (pos_valid & ~pos_valid_q) | diff1 | diff2;
  assign tc      = (cnt == CNT_LAST);
  assign moving  = (state == S_MOVE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pos_valid_q <= 1'b0;
      p1_disp     <= 4'd0;
      p2_disp     <= 4'd0;
      mover_id    <= 1'b0;
      step_pulse  <= 1'b0;
      turn_done   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pos_valid_q <= pos_valid;
      p1_disp     <= p1_n;
      p2_disp     <= p2_n;
      mover_id    <= mover_n;
      step_pulse  <= step_n;
      turn_done   <= done_n;
    end
  end

  // Displays only ever step toward a clamped target, so they stay within 0..MAX_POS.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p1_n    = p1_disp;
    p2_n    = p2_disp;
    mover_n = mover_id;
    step_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger) begin
          state_n = S_MOVE;
          cnt_n   = '0;
          if (diff1) begin
            mover_n = 1'b0;
          end else if (diff2) begin
            mover_n = 1'b1;
          end
        end
      end
      S_MOVE: begin
        if (tc) begin
          cnt_n = '0;
          if (diff1) begin
            mover_n = 1'b0;
            step_n  = 1'b1;
            p1_n    = (p1_disp < tgt1) ? p1_disp + 4'd1 : p1_disp - 4'd1;
          end else if (diff2) begin
            mover_n = 1'b1;
            step_n  = 1'b1;
            p2_n    = (p2_disp < tgt2) ? p2_disp + 4'd1 : p2_disp - 4'd1;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_token_move_animator.sv
// tb/tb_token_move_animator.sv - scoreboard bench for token_move_animator
module tb_token_move_animator;

  localparam int STEP = 4;
  localparam int MAXP = 10;

  logic       clk;
  logic       reset_n;
  logic       pos_valid;
  logic [3:0] p1_pos, p2_pos;
  logic [3:0] p1_disp, p2_disp;
  logic       moving, mover_id, step_pulse, turn_done;

  token_move_animator #(.STEP_CYCLES(STEP), .MAX_POS(MAXP)) dut (
    .clk(clk), .reset_n(reset_n), .pos_valid(pos_valid),
    .p1_pos(p1_pos), .p2_pos(p2_pos),
    .p1_disp(p1_disp), .p2_disp(p2_disp),
    .moving(moving), .mover_id(mover_id),
    .step_pulse(step_pulse), .turn_done(turn_done)
  );

  typedef struct {
    int kind;  // 0 = square step, 1 = turn_done
    int cyc;
    int p1;
    int p2;
    int mv;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  m1 = 0, m2 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Independent model: P1 walks fully first, then P2; dwell then turn_done.
  task automatic push_move(input int t0, input int a, input int b);
    int c1, c2, n;
    ev_t e;
    c1 = (a > MAXP) ? MAXP : a;
    c2 = (b > MAXP) ? MAXP : b;
    n = 0;
    while (m1 != c1) begin
      m1 = (m1 < c1) ? m1 + 1 : m1 - 1;
      n++;
      e = '{0, t0 + n * STEP, m1, m2, 0};
      sb.push_back(e);
    end
    while (m2 != c2) begin
      m2 = (m2 < c2) ? m2 + 1 : m2 - 1;
      n++;
      e = '{0, t0 + n * STEP, m1, m2, 1};
      sb.push_back(e);
    end
    e = '{1, t0 + (n + 1) * STEP + 1, m1, m2, 0};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && (step_pulse || turn_done)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("event_kind", int'(turn_done), e.kind);
        check("event_cycle", cyc, e.cyc);
        check("p1_disp", int'(p1_disp), e.p1);
        check("p2_disp", int'(p2_disp), e.p2);
        if (e.kind == 0) check("mover_id", int'(mover_id), e.mv);
      end
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    sb.delete();
    repeat (3 * STEP) @(negedge clk);
  endtask

  task automatic drive(input logic pv, input int a, input int b);
    @(negedge clk);
    p1_pos    = 4'(a);
    p2_pos    = 4'(b);
    pos_valid = pv;
    push_move(cyc + 1, a, b);
    repeat (2) @(negedge clk);
    pos_valid = 1'b0;
    wait_drain(400);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_p1_disp"}, int'(p1_disp), 0);
    check({tag, "_p2_disp"}, int'(p2_disp), 0);
    check({tag, "_moving"}, int'(moving), 0);
    check({tag, "_mover_id"}, int'(mover_id), 0);
    check({tag, "_step_pulse"}, int'(step_pulse), 0);
    check({tag, "_turn_done"}, int'(turn_done), 0);
  endtask

  initial begin
    reset_n   = 1'b1;
    pos_valid = 1'b0;
    p1_pos    = 4'd0;
    p2_pos    = 4'd0;
    #1 reset_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    drive(1'b1, 3, 0);    // three-square P1 move, exact latency
    drive(1'b0, 0, 0);    // target forced back to start, no pos_valid
    drive(1'b1, 2, 1);    // both differ: P1 first, then P2
    drive(1'b1, 2, 5);    // P2 to 5
    drive(1'b1, 2, 5);    // zero-square move: dwell only
    drive(1'b1, 2, 14);   // clamped at MAX_POS
    drive(1'b1, 0, 0);    // back home for the reset scenario

    // Reset mid-move aborts with no turn_done, then motion restarts from 0.
    @(negedge clk);
    p1_pos = 4'd5;
    push_move(cyc + 1, 5, 0);
    for (int i = 0; i < 200 && p1_disp != 4'd2; i++) @(negedge clk);
    check("reached_mid", int'(p1_disp), 2);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    sb.delete();
    m1 = 0;
    m2 = 0;
    @(negedge clk);
    check("held_in_reset", int'(moving), 0);
    @(negedge clk);
    reset_n = 1'b1;
    push_move(cyc + 1, 5, 0);
    wait_drain(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
